conway_life_engine: RTL
=======================

Name: conway_life_engine

Overview:
- Parametrised Game-of-Life board engine; successor to the fixed 8x8 toroidal updater in the terminal Conway design.
- Holds the board and executes CLEAR / RANDOM / STEP / TOGGLE commands over a valid/ready handshake.
- Supports configurable board size, toroidal or dead-border edges, and arbitrary B/S rule masks.
- Exposes a combinational cell read port for the UART display FSM, plus generation, population and stability status.

Parameters:
- LOG_W, 3, log2 of board width (W = 2**LOG_W).
- LOG_H, 3, log2 of board height (H = 2**LOG_H); N = W*H cells, cell index = y*W + x.
- WRAP, 1, 1 = toroidal edges; 0 = cells outside the board count as dead.
- BIRTH_MASK, 9'b000001000, bit n set: a dead cell with n live neighbours is born (default B3).
- SURVIVE_MASK, 9'b000001100, bit n set: a live cell with n live neighbours survives (default S23).
- GEN_W, 16, width of the generation counter.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: engine idle and able to accept a command.
- cmd_op, in, 2: 0=CLEAR, 1=RANDOM, 2=STEP, 3=TOGGLE.
- cmd_addr, in, LOG_W+LOG_H: cell index for TOGGLE; ignored for other ops.
- rng_bit, in, 1: random bit, sampled once per cell during RANDOM.
- rd_addr, in, LOG_W+LOG_H: display read address.
- rd_data, out, 1: current board cell at rd_addr (combinational).
- done, out, 1: one-cycle pulse on command completion.
- generation, out, GEN_W: count of completed STEPs.
- population, out, LOG_W+LOG_H+1: live-cell count of the current board.
- stable, out, 1: last STEP changed no cell.

Behaviour:
- Reset values: cmd_ready=1, done=0, generation=0, population=0, stable=0, FSM in IDLE.
- Reset does not clear board contents. The board is undefined until the first CLEAR or RANDOM.
- Reset mid-command aborts the command immediately; no done pulse is issued.
- Handshake:
  - A command is accepted only on a cycle where cmd_valid && cmd_ready.
  - cmd_ready is high only in IDLE; it drops the cycle after acceptance.
  - cmd_op and cmd_addr are captured at acceptance.
  - cmd_valid while busy is not accepted; it is held off by the source.
- States: IDLE, FILL, EVAL, COMMIT, TOG.
- FILL (CLEAR/RANDOM):
  - Writes cells 0..N-1, one per cycle, with 0 (CLEAR) or rng_bit (RANDOM).
  - Population is accumulated from the written bits.
  - generation and stable are cleared.
- EVAL (STEP):
  - Per cell: 8 cycles accumulate neighbours in order (-1,+1),(0,+1),(+1,+1),(-1,0),(+1,0),(-1,-1),(0,-1),(+1,-1); 1 cycle writes the next-state buffer.
  - Next state = alive ? SURVIVE_MASK[n] : BIRTH_MASK[n], with n in 0..8 (4-bit count).
  - WRAP=1: coordinates wrap modulo W and H.
  - WRAP=0: any out-of-range neighbour contributes 0.
  - A sticky "changed" flag sets if any next state differs from the current state.
- COMMIT:
  - Copies the next-state buffer to the board, one cell per cycle, cells 0..N-1.
  - Population is recomputed from the copied bits.
  - On exit: generation += 1 (wraps at 2**GEN_W); stable = ~changed.
- TOG: inverts cell cmd_addr in one cycle; population ±1; generation and stable unchanged.
- Latency from acceptance cycle to done pulse:
  - CLEAR/RANDOM: N+1 cycles.
  - STEP: 10N+1 cycles.
  - TOGGLE: 2 cycles.
- done coincides with the first IDLE cycle (cmd_ready=1). A new command may be accepted in that same cycle.
- rd_data is always the live board array. It is guaranteed coherent only while cmd_ready=1, and the display reads only then. population is likewise valid only in IDLE.
- STEP evaluates all cells against the pre-step board; no partial update is visible before COMMIT.

Test Plan:
- Reset, then CLEAR on 8x8 -> done 65 cycles after acceptance; population=0; every rd_addr reads 0; generation=0.
- TOGGLE cells 9,10,11 (horizontal blinker, WRAP=1), then STEP -> done 641 cycles after acceptance; cells 2,10,18 live, all others dead; population=3; generation=1; stable=0. A second STEP restores 9,10,11; generation=2.
- 2x2 block at cells 0,1,8,9 with WRAP=0, then STEP -> board unchanged; population=4; stable=1. Same block with WRAP=1 and LOG_W=LOG_H=1 -> all 4 cells die (each sees 8 live neighbours); population=0.
- RANDOM with rng_bit tied to 1 -> all N cells live; population=N (64). STEP -> all cells die (n=8); population=0; stable=0.
- Assert cmd_valid during an EVAL -> cmd_ready=0 and the command is not accepted; it is accepted on the done cycle. Assert reset mid-COMMIT -> cmd_ready=1, generation=0 and no done pulse on the next cycle.
- Rule masks B36/S23 (BIRTH_MASK=9'b001001000): a dead cell with exactly 6 live neighbours becomes live after STEP.

Source files
------------

// File: rtl/conway_life_engine.sv
// Game-of-Life board engine: holds a 2**LOG_W x 2**LOG_H board and runs
// CLEAR / RANDOM / STEP / TOGGLE commands over a valid/ready handshake.
module conway_life_engine #(
  parameter int         LOG_W        = 3,
  parameter int         LOG_H        = 3,
  parameter int         WRAP         = 1,
  parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
  parameter int         GEN_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [LOG_W+LOG_H-1:0] cmd_addr,
  input  logic                   rng_bit,
  input  logic [LOG_W+LOG_H-1:0] rd_addr,
  output logic                   rd_data,
  output logic                   done,
  output logic [GEN_W-1:0]       generation,
  output logic [LOG_W+LOG_H:0]   population,
  output logic                   stable
);

  localparam int AW = LOG_W + LOG_H;
  localparam int N  = 1 << AW;

  localparam logic [1:0] OP_CLEAR  = 2'd0;
  localparam logic [1:0] OP_RANDOM = 2'd1;
  localparam logic [1:0] OP_STEP   = 2'd2;

  localparam logic [LOG_W:0] DX_M = {(LOG_W+1){1'b1}};
  localparam logic [LOG_W:0] DX_Z = {(LOG_W+1){1'b0}};
  localparam logic [LOG_W:0] DX_P = {{LOG_W{1'b0}}, 1'b1};
  localparam logic [LOG_H:0] DY_M = {(LOG_H+1){1'b1}};
  localparam logic [LOG_H:0] DY_Z = {(LOG_H+1){1'b0}};
  localparam logic [LOG_H:0] DY_P = {{LOG_H{1'b0}}, 1'b1};

  // Masks widened so a 4-bit count indexes them without range issues.
  localparam logic [15:0] BIRTH16   = {7'b0000000, BIRTH_MASK};
  localparam logic [15:0] SURVIVE16 = {7'b0000000, SURVIVE_MASK};

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_EVAL, S_COMMIT, S_TOG} state_t;

  state_t           r_state;
  logic             r_ready;
  logic             r_done;
  logic [GEN_W-1:0] r_gen;
  logic [AW:0]      r_pop;
  logic             r_stable;
  logic             r_fill_rnd;
  logic [AW-1:0]    r_addr;
  logic [AW-1:0]    r_idx;
  logic [3:0]       r_phase;
  logic [3:0]       r_cnt;
  logic             r_changed;
  logic             r_board [N];
  logic             r_next  [N];

  logic [LOG_W:0]   w_dx;
  logic [LOG_H:0]   w_dy;
  logic [LOG_W:0]   w_nx;
  logic [LOG_H:0]   w_ny;
  logic             w_in_range;
  logic [AW-1:0]    w_nb_addr;
  logic             w_nb_bit;
  logic             w_alive;
  logic             w_next;
  logic             w_last;
  logic             w_fill_bit;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_addr;
  logic             w_wr_data;

  assign cmd_ready  = r_ready;
  assign done       = r_done;
  assign generation = r_gen;
  assign population = r_pop;
  assign stable     = r_stable;
  assign rd_data    = r_board[rd_addr];

  // Neighbour offset for the current accumulation phase.
  always_comb begin
    w_dx = DX_Z;
    w_dy = DY_Z;
    case (r_phase)
      4'd0:    begin w_dx = DX_M; w_dy = DY_P; end
      4'd1:    begin w_dx = DX_Z; w_dy = DY_P; end
      4'd2:    begin w_dx = DX_P; w_dy = DY_P; end
      4'd3:    begin w_dx = DX_M; w_dy = DY_Z; end
      4'd4:    begin w_dx = DX_P; w_dy = DY_Z; end
      4'd5:    begin w_dx = DX_M; w_dy = DY_M; end
      4'd6:    begin w_dx = DX_Z; w_dy = DY_M; end
      4'd7:    begin w_dx = DX_P; w_dy = DY_M; end
      default: begin w_dx = DX_Z; w_dy = DY_Z; end
    endcase
  end

  // The extra top bit flags a step off either edge of the board.
  assign w_nx       = {1'b0, r_idx[LOG_W-1:0]} + w_dx;
  assign w_ny       = {1'b0, r_idx[AW-1:LOG_W]} + w_dy;
  assign w_in_range = (WRAP != 0) || (!w_nx[LOG_W] && !w_ny[LOG_H]);
  assign w_nb_addr  = {w_ny[LOG_H-1:0], w_nx[LOG_W-1:0]};
  assign w_nb_bit   = r_board[w_nb_addr] & w_in_range;
  assign w_alive    = r_board[r_idx];
  assign w_next     = w_alive ? SURVIVE16[r_cnt] : BIRTH16[r_cnt];
  assign w_last     = &r_idx;
  assign w_fill_bit = r_fill_rnd & rng_bit;

  // Single board write port shared by FILL, COMMIT and TOG.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_idx;
    w_wr_data = 1'b0;
    case (r_state)
      S_FILL:   begin w_wr_en = 1'b1; w_wr_data = w_fill_bit; end
      S_COMMIT: begin w_wr_en = 1'b1; w_wr_data = r_next[r_idx]; end
      S_TOG:    begin w_wr_en = 1'b1; w_wr_addr = r_addr; w_wr_data = ~r_board[r_addr]; end
      default:  begin w_wr_en = 1'b0; end
    endcase
  end

  // Board storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en && !reset) begin
      r_board[w_wr_addr] <= w_wr_data;
    end
    if ((r_state == S_EVAL) && (r_phase == 4'd8) && !reset) begin
      r_next[r_idx] <= w_next;
    end
  end

  // Command FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_gen      <= {GEN_W{1'b0}};
      r_pop      <= {(AW+1){1'b0}};
      r_stable   <= 1'b0;
      r_fill_rnd <= 1'b0;
      r_addr     <= {AW{1'b0}};
      r_idx      <= {AW{1'b0}};
      r_phase    <= 4'd0;
      r_cnt      <= 4'd0;
      r_changed  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_ready <= 1'b0;
            r_idx   <= {AW{1'b0}};
            r_phase <= 4'd0;
            r_cnt   <= 4'd0;
            r_addr  <= cmd_addr;
            case (cmd_op)
              OP_CLEAR, OP_RANDOM: begin
                r_state    <= S_FILL;
                r_fill_rnd <= (cmd_op == OP_RANDOM);
                r_pop      <= {(AW+1){1'b0}};
                r_gen      <= {GEN_W{1'b0}};
                r_stable   <= 1'b0;
              end
              OP_STEP: begin
                r_state   <= S_EVAL;
                r_changed <= 1'b0;
              end
              default: r_state <= S_TOG;
            endcase
          end
        end
        S_FILL: begin
          r_pop <= r_pop + {{AW{1'b0}}, w_fill_bit};
          r_idx <= r_idx + {{(AW-1){1'b0}}, 1'b1};
          if (w_last) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        S_EVAL: begin
          if (r_phase == 4'd8) begin
            r_phase <= 4'd0;
            r_cnt   <= 4'd0;
            r_idx   <= r_idx + {{(AW-1){1'b0}}, 1'b1};
            if (w_next != w_alive) r_changed <= 1'b1;
            if (w_last) begin
              r_state <= S_COMMIT;
              r_pop   <= {(AW+1){1'b0}};
            end
          end else begin
            r_cnt   <= r_cnt + {3'b000, w_nb_bit};
            r_phase <= r_phase + 4'd1;
          end
        end
        S_COMMIT: begin
          r_pop <= r_pop + {{AW{1'b0}}, r_next[r_idx]};
          r_idx <= r_idx + {{(AW-1){1'b0}}, 1'b1};
          if (w_last) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b1;
            r_gen    <= r_gen + {{(GEN_W-1){1'b0}}, 1'b1};
            r_stable <= ~r_changed;
          end
        end
        S_TOG: begin
          r_pop   <= r_board[r_addr] ? (r_pop - {{AW{1'b0}}, 1'b1})
                                     : (r_pop + {{AW{1'b0}}, 1'b1});
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
